// File: rtl/dmem_target.sv
// Wait-state data-memory responder: one outstanding load/store through valid/ready,
// programmable wait states, byte-masked writes and registered responses.
module dmem_target #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]    r_cnt;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_access;
    logic          w_do_write;
    logic          w_err;
    logic [31:0]   w_off;
    logic [29:0]   w_word;
    logic [IW-1:0] w_idx;
    logic          w_unused;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid)   w_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
            S_RESP:  if (resp_ready)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decode state only; reset additionally gates req_ready
    always_comb begin
        req_ready  = (r_state == S_IDLE) && reset;
        resp_valid = (r_state == S_RESP);
        busy       = (r_state != S_IDLE);
    end

    assign w_accept = req_valid && req_ready;
    assign w_access = (r_state == S_WAIT) && (r_cnt == '0);

    assign w_off    = r_addr - BASE_ADDR;
    assign w_word   = w_off[31:2];
    assign w_idx    = w_word[IW-1:0];
    assign w_err    = (r_addr < BASE_ADDR) || (w_word >= 30'(DEPTH));
    assign w_unused = ^w_off[1:0];

    // Request latch, wait counter and registered response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_cnt   <= 4'(WAIT_CYCLES);
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (!r_we && !w_err) ? r_mem[w_idx] : '0;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // Array is not reset; reset low on the access edge suppresses the write
    assign w_do_write = w_access && reset && r_we && !w_err;

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_target.sv
// Directed self-checking bench for dmem_target (DEPTH=64, WAIT_CYCLES=2, BASE_ADDR=0).
module tb_dmem_target;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    dmem_target #(
        .DEPTH       (64),
        .WAIT_CYCLES (2),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: accept, count edges to response, check, handshake.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        tick();
        req_valid = 1'b0;
        req_wdata = 32'hA5A5_A5A5;
        n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, n, 32'd3);
        chk({tag, ".rdata"}, resp_rdata, exp_rdata);
        chk({tag, ".err"}, {31'b0, resp_err}, {31'b0, exp_err});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, ".idle"}, {30'b0, busy, resp_valid}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        resp_ready = 1'b0;

        // Reset held with a request pending
        #2;
        reset     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        tick();
        tick();
        chk("rst.req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.err", {31'b0, resp_err}, 32'd0);
        req_valid = 1'b0;
        reset     = 1'b1;
        tick();
        chk("rel.req_ready", {31'b0, req_ready}, 32'd1);
        chk("rel.busy", {31'b0, busy}, 32'd0);

        // Full-word round trip and byte-enable merge
        txn("st_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
        txn("ld_full", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0);
        txn("st_be5", 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        txn("ld_be5", 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDE22_BE44, 1'b0);
        txn("st_be0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
        txn("ld_be0", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE22_BE44, 1'b0);
        txn("ld_lowbits", 1'b0, 32'h13, 32'h0, 4'b0000, 32'hDE22_BE44, 1'b0);

        // Range boundaries: last word is legal, index 64 errors and does not alias
        txn("st_last", 1'b1, 32'hFC, 32'h5A5A_5A5A, 4'b1111, 32'h0, 1'b0);
        txn("st_w0", 1'b1, 32'h0, 32'h0102_0304, 4'b1111, 32'h0, 1'b0);
        txn("st_oor", 1'b1, 32'h100, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1);
        txn("ld_oor", 1'b0, 32'h100, 32'h0, 4'b0000, 32'h0, 1'b1);
        txn("ld_last", 1'b0, 32'hFC, 32'h0, 4'b0000, 32'h5A5A_5A5A, 1'b0);
        txn("ld_w0", 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0102_0304, 1'b0);

        // Response backpressure with a competing request held high
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        tick();
        req_we    = 1'b1;
        req_wdata = 32'h0BAD_0BAD;
        req_be    = 4'b1111;
        for (int i = 0; i < 20 && !resp_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", {31'b0, resp_valid}, 32'd1);
            chk("bp.rdata", resp_rdata, 32'hDE22_BE44);
            chk("bp.err", {31'b0, resp_err}, 32'd0);
            chk("bp.req_ready", {31'b0, req_ready}, 32'd0);
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("bp.release_ready", {31'b0, req_ready}, 32'd1);
        chk("bp.release_busy", {31'b0, busy}, 32'd0);
        txn("bp.ld_after", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE22_BE44, 1'b0);

        // Reset during WAIT drops the pending store
        txn("mid.st_prior", 1'b1, 32'h20, 32'h1357_2468, 4'b1111, 32'h0, 1'b0);
        txn("mid.ld_prior", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h1357_2468, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFE_F00D;
        req_be    = 4'b1111;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid.busy_wait", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid.busy_rst", {31'b0, busy}, 32'd0);
        chk("mid.ready_rst", {31'b0, req_ready}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("mid.ready_rel", {31'b0, req_ready}, 32'd1);
        tick();
        tick();
        chk("mid.no_resp", {31'b0, resp_valid}, 32'd0);
        txn("mid.ld_after", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h1357_2468, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
